// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type and address-field width helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic {
        DmemIdle,
        DmemResp
    } dmem_state_e;

    function automatic int ob_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, per-byte write enable, synchronous read
module dmem_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [WIDTH/8-1:0]   i_wstrb,
    input  logic [AW-1:0]        i_addr,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    // Read register only loads on a read access, so a held response stays stable.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_wstrb[b]) begin
                        mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                o_rdata <= mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - LSU data-memory responder with registered response
// Optional access-error checking is enabled by defining DMEM_ERR_EN.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic              i_req_we,
    input  logic [XLEN/8-1:0] i_req_wstrb,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int OB = ob_w(XLEN);
    localparam int IW = idx_w(DEPTH);

    dmem_state_e       state_q, state_d;
    logic              load_q, load_d;
    logic              err_q, err_d;
    logic              accept;
    logic              req_err;
    logic [IW-1:0]     idx;
    logic [XLEN-1:0]   ram_rdata;

    assign o_rsp_valid = (state_q == DmemResp);
    assign o_req_ready = !o_rsp_valid || i_rsp_ready;
    assign accept      = i_req_valid && o_req_ready;
    assign idx         = i_req_addr[IW+OB-1:OB];

`ifdef DMEM_ERR_EN
    assign req_err   = (|i_req_addr[OB-1:0]) || (|i_req_addr[XLEN-1:IW+OB]);
    assign o_rsp_err = err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[OB-1:0], i_req_addr[XLEN-1:IW+OB], err_q};
    assign req_err   = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    // Stores and errored accesses answer with zero data; only clean loads expose the RAM word.
    assign o_rsp_rdata = load_q ? ram_rdata : '0;

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            DmemIdle: begin
                if (accept) begin
                    state_d = DmemResp;
                    load_d  = !i_req_we && !req_err;
                    err_d   = req_err;
                end
            end
            DmemResp: begin
                if (accept) begin
                    load_d = !i_req_we && !req_err;
                    err_d  = req_err;
                end else if (i_rsp_ready) begin
                    state_d = DmemIdle;
                end
            end
            default: state_d = DmemIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= DmemIdle;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    dmem_ram #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH),
        .AW    (IW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (accept && !req_err),
        .i_we    (i_req_we),
        .i_wstrb (i_req_wstrb),
        .i_addr  (idx),
        .i_wdata (i_req_wdata),
        .o_rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed bench with transaction-level memory model
module tb_data_memory_responder;

    localparam int XLEN = 32;
    localparam int D    = 64;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_we;
    logic [3:0]  i_req_wstrb;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    always #5 i_clk = ~i_clk;

    data_memory_responder #(.XLEN(XLEN), .DEPTH(D)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_we    (i_req_we),
        .i_req_wstrb (i_req_wstrb),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err)
    );

    // Model: one held response slot and a word array.
    logic [31:0] m_mem [D];
    bit          m_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          m_err   = 1'b0;

    always @(posedge i_clk) begin
        bit acc;
        bit bad;
        int w;
        if (!i_rst_n) begin
            m_valid = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
        end else begin
            acc = i_req_valid && (!m_valid || i_rsp_ready);
            if (acc) begin
                w = int'((i_req_addr / 4) % D);
`ifdef DMEM_ERR_EN
                bad = (i_req_addr % 4 != 0) || (i_req_addr >= D * 4);
`else
                bad = 1'b0;
`endif
                if (i_req_we && !bad) begin
                    for (int b = 0; b < 4; b++)
                        if (i_req_wstrb[b]) m_mem[w][b*8 +: 8] = i_req_wdata[b*8 +: 8];
                end
                m_rdata = (i_req_we || bad) ? 32'h0 : m_mem[w];
                m_err   = bad;
                m_valid = 1'b1;
            end else if (i_rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (started) begin
            chk("req_ready", {31'd0, o_req_ready}, {31'd0, !m_valid || i_rsp_ready});
            chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, m_valid});
            if (m_valid || !i_rst_n) begin
                chk("rsp_rdata", o_rsp_rdata, m_rdata);
                chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, m_err});
            end
        end
    end

    task automatic drive(input bit v, input bit we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input bit rr);
        i_req_valid = v;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wstrb = s;
        i_req_wdata = d;
        i_rsp_ready = rr;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int acc_cnt;
        i_rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        step();
        started = 1'b1;
        step();
        i_rst_n = 1'b1;
        step();
        chk("reset_ready", {31'd0, o_req_ready}, 32'd1);
        chk("reset_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("reset_rdata", o_rsp_rdata, 32'd0);

        // Store then back-to-back load of the same word.
        drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1); step();
        chk("store_rdata_zero", o_rsp_rdata, 32'd0);
        drive(1, 0, 32'h10, 4'h0, 32'h0, 1); step();
        drive(0, 0, 0, 0, 0, 1);
        chk("raw_full_word", o_rsp_rdata, 32'hDEADBEEF);
        step();

        // Single-lane merge.
        drive(1, 1, 32'h10, 4'h1, 32'h000000AA, 1); step();
        drive(1, 0, 32'h10, 4'h0, 32'h0, 1); step();
        drive(0, 0, 0, 0, 0, 1);
        chk("raw_byte_merge", o_rsp_rdata, 32'hDEADBEAA);
        step();

        // Zero-strobe store changes nothing.
        drive(1, 1, 32'h10, 4'h0, 32'h11111111, 1); step();
        drive(1, 0, 32'h10, 4'h0, 32'h0, 1); step();
        drive(0, 0, 0, 0, 0, 1);
        chk("zero_strobe", o_rsp_rdata, 32'hDEADBEAA);

        // Fill 8 words, then 8 consecutive loads.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'h20 + 4 * i, 4'hF, 32'hA5000000 + 32'(i * 32'h00010101), 1);
            step();
        end
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'h20 + 4 * i, 4'h0, 32'h0, 1);
            #1;
            if (o_req_ready) acc_cnt++;
            step();
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("eight_accepts", 32'(acc_cnt), 32'd8);
        chk("last_of_eight", o_rsp_rdata, 32'hA5070707);
        step();

        // Backpressure for 3 cycles with a pending request.
        drive(1, 0, 32'h10, 4'h0, 32'h0, 0); step();
        drive(1, 0, 32'h24, 4'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", {31'd0, o_req_ready}, 32'd0);
            chk("bp_rdata_hold", o_rsp_rdata, 32'hDEADBEAA);
            step();
        end
        drive(1, 0, 32'h24, 4'h0, 32'h0, 1);
        #1;
        chk("bp_release_ready", {31'd0, o_req_ready}, 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        chk("bp_new_rsp", o_rsp_rdata, 32'hA5010101);
        step();

        // Word 0, then error or wrap behaviour.
        drive(1, 1, 32'h0, 4'hF, 32'h12345678, 1); step();
`ifdef DMEM_ERR_EN
        drive(1, 1, 32'h12, 4'hF, 32'hFFFFFFFF, 1); step();
        chk("misaligned_err", {31'd0, o_rsp_err}, 32'd1);
        drive(1, 0, D * 4, 4'h0, 32'h0, 1); step();
        chk("oor_err", {31'd0, o_rsp_err}, 32'd1);
        chk("oor_rdata", o_rsp_rdata, 32'd0);
        drive(1, 0, 32'h10, 4'h0, 32'h0, 1); step();
        chk("err_no_write", o_rsp_rdata, 32'hDEADBEAA);
`else
        drive(1, 0, D * 4, 4'h0, 32'h0, 1); step();
        chk("wrap_word0", o_rsp_rdata, 32'h12345678);
`endif
        drive(0, 0, 0, 0, 0, 1); step();

        // Reset while a response is held.
        drive(1, 0, 32'h10, 4'h0, 32'h0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("held_before_reset", {31'd0, o_rsp_valid}, 32'd1);
        i_rst_n = 1'b0;
        step();
        chk("reset_drops_valid", {31'd0, o_rsp_valid}, 32'd0);
        i_rst_n = 1'b1;
        drive(1, 0, 32'h10, 4'h0, 32'h0, 1); step();
        drive(0, 0, 0, 0, 0, 1);
        chk("ram_survives_reset", o_rsp_rdata, 32'hDEADBEAA);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's data-memory bus: it accepts load/store requests issued by the load-store unit, services them against an internal word-organised RAM with byte-strobed writes, and returns a registered response one cycle later. It sits between the execute stage's LSU port and the data RAM. A valid/ready handshake gives single-cycle throughput and full backpressure.

## Interface
- XLEN, 32, data and address width; must be 32 or 64
- DEPTH, 1024, number of XLEN-bit words; power of two
- i_clk  in  1  clock; all logic on the rising edge
- i_rst_n  in  1  reset, synchronous and active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  responder can accept a request this cycle
- i_req_addr  in  XLEN  byte address
- i_req_we  in  1  1 = store, 0 = load
- i_req_wstrb  in  XLEN/8  byte enables for stores; ignored for loads
- i_req_wdata  in  XLEN  store data, byte lanes aligned to the word
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  requester consumes the response
- o_rsp_rdata  out  XLEN  load data; 0 for stores and errored accesses
- o_rsp_err  out  1  access error, only when DMEM_ERR_EN is defined

## Operation
- Two states: IDLE (no response held) and RESP (response held in the output register).
- o_req_ready = !o_rsp_valid || i_rsp_ready. This is combinational and pipelined, so back-to-back accepts are possible.
- Accept condition: i_req_valid && o_req_ready.
- Word index: i_req_addr[log2(DEPTH)+OB-1:OB], where OB = log2(XLEN/8).
- Load accepted: mem[index] is registered into o_rsp_rdata.
- Store accepted:
  - Each lane b with i_req_wstrb[b]=1 writes i_req_wdata byte b at the accept edge.
  - Other lanes are unchanged.
  - Response data is 0.
  - A store with wstrb all zero changes nothing and is acknowledged normally.
- Every accept produces exactly one response, in request order.
- Transitions:
  - IDLE → RESP on accept.
  - RESP → RESP on accept with i_rsp_ready (new response replaces the consumed one).
  - RESP → IDLE on i_rsp_ready without accept.
  - RESP holds while i_rsp_ready = 0.
- While held, o_rsp_rdata and o_rsp_err must stay stable.
- RAM contents are not reset.

## Timing
- Reset values: o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_req_ready=1 in the cycle after reset deasserts.
- Latency: a request accepted at edge N has its response valid from edge N (visible in cycle N+1).
- Read after write: a store accepted at edge N followed by a load to the same word accepted at edge N+1 returns the new data. Byte lanes merge correctly.
- Backpressure: with i_rsp_ready=0 and o_rsp_valid=1, o_req_ready=0 and no RAM write occurs.
- Reset asserted mid-operation: the held response is discarded. Stores already accepted remain in RAM; no partial write is possible.

## Configuration
- DMEM_ERR_EN defined:
  - An access is errored if i_req_addr[OB-1:0] != 0 (misaligned) or i_req_addr bits above the index are nonzero (out of range).
  - An errored access writes nothing, returns rdata=0 and err=1, and still completes through the handshake.
- DMEM_ERR_EN undefined:
  - o_rsp_err is tied to 0.
  - Low offset bits and upper address bits are ignored, so the address wraps modulo DEPTH words.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (DmemIdle, DmemResp)
  - the byte-offset and index-width localparam functions.
- One sub-module, dmem_ram: a single-port word RAM with a per-byte write enable and synchronous read. It infers block RAM; the read address is sampled only on accept, so the output holds.
- The handshake, state and error logic live in the top module.

## Test plan
- Store 0xDEADBEEF to 0x10 with wstrb=4'hF, then load 0x10 back-to-back → the load response is 0xDEADBEEF one cycle after its accept.
- Store 0x000000AA to 0x10 with wstrb=4'h1 over 0xDEADBEEF → a subsequent load returns 0xDEADBEAA.
- Load issued, i_rsp_ready held 0 for 3 cycles → o_req_ready=0, rdata stable for 3 cycles, a new request is accepted in the cycle i_rsp_ready=1.
- 8 consecutive loads with i_rsp_ready=1 → 8 accepts in 8 cycles, responses in order.
- With DMEM_ERR_EN, store to 0x12 and then load from DEPTH*4 → both respond err=1 with rdata 0, and the RAM is unchanged. Without the macro, a load from DEPTH*4 returns word 0.
- Assert i_rst_n=0 while a response is held → o_rsp_valid=0 the next cycle, and RAM contents written earlier are still readable.
